sha256_compress: RTL

SHA256_COMPRESS -- requirements
Module: sha256_compress

---
 rtl/sha256_compress.sv | 99 +++++++++
 1 files changed

// File: rtl/sha256_compress.sv
// SHA-256 compression core: one 512-bit block per 67 cycles, one round per clock.
// The schedule word for the current round is supplied externally, selected by round.
module sha256_compress (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [255:0] hash_in,
    input  logic [31:0]  w_word,
    output logic [5:0]   round,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, ADD} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t state, state_nxt;

    // hreg[7] is H0, matching the hash_in packing so capture is a plain copy.
    logic [7:0][31:0] hreg;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] s0, s1, ch, maj, t1, t2;

    assign busy = (state != IDLE);

    always_comb begin
        s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
        ch  = (e & f) ^ (~e & g);
        t1  = h + s1 + ch + K[round] + w_word;
        s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
        maj = (a & b) ^ (a & c) ^ (b & c);
        t2  = s0 + maj;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = ROUND;
            ROUND:   if (round == 6'd63) state_nxt = ADD;
            ADD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            round    <= '0;
            done     <= 1'b0;
            hash_out <= '0;
            hreg     <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) hreg <= hash_in;
                LOAD: begin
                    {a, b, c, d, e, f, g, h} <= hreg;
                    round <= '0;
                end
                ROUND: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    // 6-bit counter wraps 63 -> 0 on the way into ADD
                    round <= round + 6'd1;
                end
                ADD: begin
                    hash_out <= {hreg[7] + a, hreg[6] + b, hreg[5] + c, hreg[4] + d,
                                 hreg[3] + e, hreg[2] + f, hreg[1] + g, hreg[0] + h};
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
